// File: rtl/snn_sched_pkg.sv
// Shared scheduler types and layer geometry. The PE and packet-injector blocks
// use the same defaults.
package snn_sched_pkg;

    localparam int NUM_PE   = 5;
    localparam int NUM_ROWS = 21;
    localparam int NUM_TS   = 2;
    localparam int PE_W     = 3;
    localparam int ROW_W    = 5;
    localparam int TS_W     = 2;

    typedef logic [PE_W-1:0]  pe_id_t;
    typedef logic [ROW_W-1:0] row_t;
    typedef logic [TS_W-1:0]  ts_t;

    typedef enum logic [2:0] {
        IDLE,
        DISPATCH,
        DRAIN,
        TS_END,
        DONE
    } sched_state_e;

    // Successor of a PE ID in round-robin order, wrapping at NUM_PE.
    function automatic pe_id_t pe_next(input pe_id_t p);
        return (p == pe_id_t'(NUM_PE - 1)) ? pe_id_t'(0) : p + pe_id_t'(1);
    endfunction

endpackage

// File: rtl/spe_rr_pick.sv
// Combinational round-robin picker: returns the first available PE at or after
// rr_ptr, wrapping modulo NUM_PE.
module spe_rr_pick
    import snn_sched_pkg::*;
(
    input  logic [NUM_PE-1:0] avail,
    input  logic [PE_W-1:0]   rr_ptr,
    output logic              found,
    output logic [PE_W-1:0]   pe_id
);

    logic [2*NUM_PE-1:0] dbl;
    logic [NUM_PE-1:0]   rot;
    logic [PE_W:0]       off;
    logic [PE_W:0]       sum;

    // Rotate the mask so bit 0 corresponds to rr_ptr; the lowest set bit then
    // gives the offset of the winner from the pointer.
    // NOTE: every always_comb output gets a default before any branch, so no
    // path can leave a value unassigned and infer a latch.
    always_comb begin
        dbl   = {avail, avail};
        dbl   = dbl >> rr_ptr;
        rot   = dbl[NUM_PE-1:0];
        found = |rot;
        off   = '0;
        for (int i = NUM_PE - 1; i >= 0; i--) begin
            if (rot[i]) begin
                off = (PE_W + 1)'(i);
            end
        end
        sum   = {1'b0, rr_ptr} + off;
        pe_id = (sum >= (PE_W + 1)'(NUM_PE)) ? PE_W'(sum - (PE_W + 1)'(NUM_PE))
                                             : sum[PE_W-1:0];
    end

endmodule

// File: rtl/spe_job_scheduler.sv
// Per-layer SPE job scheduler: one job per row per timestep, round-robin PE
// allocation with busy tracking, and a barrier between consecutive timesteps.
module spe_job_scheduler
    import snn_sched_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    output logic             job_valid,
    input  logic             job_ready,
    output logic [PE_W-1:0]  job_pe,
    output logic [TS_W-1:0]  job_ts,
    output logic [ROW_W-1:0] job_row,
    input  logic             cmpl_valid,
    input  logic [PE_W-1:0]  cmpl_pe,
    output logic             ts_done,
    output logic             all_done,
    output logic             busy,
    output logic             err_cmpl
);

    sched_state_e      state, state_next;
    logic [NUM_PE-1:0] pe_busy;
    logic [NUM_PE-1:0] acc_onehot;
    logic [NUM_PE-1:0] avail;
    pe_id_t            rr_ptr;
    pe_id_t            pick_ptr;
    pe_id_t            pick_pe;
    logic              pick_found;
    ts_t               ts;
    row_t              row;
    row_t              row_next;
    logic              accept;
    logic              layer_start;
    logic              cmpl_ok;
    logic              load_offer;

    assign accept      = job_valid && job_ready;
    assign layer_start = (state == IDLE) && start;
    assign row_next    = accept ? row + row_t'(1) : row;
    assign pick_ptr    = accept ? pe_next(job_pe) : rr_ptr;
    assign cmpl_ok     = cmpl_valid && (cmpl_pe < pe_id_t'(NUM_PE)) && pe_busy[cmpl_pe];

    // A PE being accepted this edge is not yet marked busy but must not be
    // offered again; a completion this edge only frees its PE for the next pick.
    always_comb begin
        acc_onehot = '0;
        if (accept) begin
            acc_onehot[job_pe] = 1'b1;
        end
    end

    assign avail      = ~(pe_busy | acc_onehot);
    assign load_offer = (state == DISPATCH) && (!job_valid || accept) &&
                        (row_next < row_t'(NUM_ROWS));

    spe_rr_pick u_pick (
        .avail  (avail),
        .rr_ptr (pick_ptr),
        .found  (pick_found),
        .pe_id  (pick_pe)
    );

    always_comb begin
        state_next = state;
        ts_done    = 1'b0;
        all_done   = 1'b0;
        busy       = (state != IDLE);
        unique case (state)
            IDLE:     if (start) state_next = DISPATCH;
            DISPATCH: if (accept && row_next == row_t'(NUM_ROWS)) state_next = DRAIN;
            DRAIN:    if (pe_busy == '0) state_next = TS_END;
            TS_END: begin
                ts_done    = 1'b1;
                state_next = (ts == ts_t'(NUM_TS)) ? DONE : DISPATCH;
            end
            DONE: begin
                all_done   = 1'b1;
                state_next = IDLE;
            end
            default:  state_next = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pe_busy  <= '0;
            rr_ptr   <= '0;
            ts       <= ts_t'(1);
            row      <= '0;
            err_cmpl <= 1'b0;
        end else begin
            if (cmpl_ok) begin
                pe_busy[cmpl_pe] <= 1'b0;
            end
            if (accept) begin
                pe_busy[job_pe] <= 1'b1;
                rr_ptr          <= pe_next(job_pe);
            end
            if (layer_start) begin
                ts  <= ts_t'(1);
                row <= '0;
            end else if (state == TS_END && ts != ts_t'(NUM_TS)) begin
                ts  <= ts + ts_t'(1);
                row <= '0;
            end else begin
                row <= row_next;
            end
            // A bad completion on the start edge still counts for the new layer.
            if (layer_start) begin
                err_cmpl <= 1'b0;
            end
            if (cmpl_valid && !cmpl_ok) begin
                err_cmpl <= 1'b1;
            end
        end
    end

    // Offer register: held unchanged until accepted, reloaded on the accept edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            job_valid <= 1'b0;
            job_pe    <= '0;
            job_ts    <= TS_W'(1);
            job_row   <= '0;
        end else if (load_offer) begin
            job_valid <= pick_found;
            if (pick_found) begin
                job_pe  <= pick_pe;
                job_ts  <= ts;
                job_row <= row_next;
            end
        end else if (accept) begin
            job_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_spe_job_scheduler.sv
// Directed bench for spe_job_scheduler: accepted jobs are checked against a
// queue of expected offers filled when each scenario's stimulus is set up.
module tb_spe_job_scheduler;
    import snn_sched_pkg::*;

    logic   clk = 1'b0;
    logic   rst_n = 1'b0;
    logic   start = 1'b0;
    logic   job_ready = 1'b0;
    logic   cmpl_valid = 1'b0;
    pe_id_t cmpl_pe = '0;
    logic   job_valid;
    pe_id_t job_pe;
    ts_t    job_ts;
    row_t   job_row;
    logic   ts_done, all_done, busy, err_cmpl;

    always #5 clk = ~clk;

    spe_job_scheduler dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .job_valid  (job_valid),
        .job_ready  (job_ready),
        .job_pe     (job_pe),
        .job_ts     (job_ts),
        .job_row    (job_row),
        .cmpl_valid (cmpl_valid),
        .cmpl_pe    (cmpl_pe),
        .ts_done    (ts_done),
        .all_done   (all_done),
        .busy       (busy),
        .err_cmpl   (err_cmpl)
    );

    typedef struct packed {
        pe_id_t pe;
        ts_t    ts;
        row_t   row;
    } job_t;

    job_t exp_q[$];
    int   n_assert = 0;
    int   n_fail = 0;
    int   cyc = 0;
    int   n_acc = 0;
    int   n_ts_done = 0;
    int   n_all_done = 0;
    int   due_at[NUM_PE];
    bit   auto_cmpl = 1'b0;
    int   lat_override_k = -1;
    int   lat_override = 0;
    int   override_due = -1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic job_t mk(input int pe, input int ts, input int row);
        job_t j;
        j.pe  = pe_id_t'(pe);
        j.ts  = ts_t'(ts);
        j.row = row_t'(row);
        return j;
    endfunction

    // Full layer with every PE completing in time: strict round-robin order.
    task automatic push_layer();
        for (int k = 0; k < NUM_ROWS * NUM_TS; k++) begin
            exp_q.push_back(mk(k % NUM_PE, 1 + k / NUM_ROWS, k % NUM_ROWS));
        end
    endtask

    // One clock: score a transfer due at the coming edge, drive any scheduled
    // completion, then sample 1 time unit after the edge.
    task automatic cycle();
        job_t e;
        if (job_valid && job_ready) begin
            check("sb_nonempty", 32'(exp_q.size() != 0), 1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("acc_pe", job_pe, e.pe);
                check("acc_ts", job_ts, e.ts);
                check("acc_row", job_row, e.row);
            end
            if (auto_cmpl && job_pe < pe_id_t'(NUM_PE)) begin
                due_at[job_pe] = cyc + 1 + ((n_acc == lat_override_k) ? lat_override : 3);
                if (n_acc == lat_override_k) override_due = due_at[job_pe];
            end
            n_acc++;
        end
        if (auto_cmpl) begin
            for (int p = 0; p < NUM_PE; p++) begin
                if (due_at[p] == cyc + 1) begin
                    cmpl_valid = 1'b1;
                    cmpl_pe    = pe_id_t'(p);
                    due_at[p]  = -1;
                end
            end
        end
        @(posedge clk);
        cyc++;
        #1;
        cmpl_valid = 1'b0;
        if (ts_done) n_ts_done++;
        if (all_done) n_all_done++;
    endtask

    task automatic clear_model();
        start = 1'b0; job_ready = 1'b0; cmpl_valid = 1'b0; cmpl_pe = '0;
        auto_cmpl = 1'b0; lat_override_k = -1; override_due = -1;
        exp_q.delete();
        foreach (due_at[p]) due_at[p] = -1;
        n_acc = 0; n_ts_done = 0; n_all_done = 0;
    endtask

    task automatic do_reset();
        clear_model();
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_all_done(input int budget);
        int got = 0;
        for (int i = 0; i < budget && got == 0; i++) begin
            cycle();
            if (all_done) got = 1;
        end
        check("all_done_seen", got, 1);
    endtask

    initial begin
        int seen;
        int tsd_cyc;

        // 1: reset values, start latency, full layer with 3-cycle completions
        do_reset();
        check("rst_valid", job_valid, 0);
        check("rst_pe", job_pe, 0);
        check("rst_ts", job_ts, 1);
        check("rst_row", job_row, 0);
        check("rst_ts_done", ts_done, 0);
        check("rst_all_done", all_done, 0);
        check("rst_busy", busy, 0);
        check("rst_err", err_cmpl, 0);
        push_layer();
        job_ready = 1'b1; auto_cmpl = 1'b1; start = 1'b1;
        cycle();
        start = 1'b0;
        check("lat_busy", busy, 1);
        check("lat_valid_early", job_valid, 0);
        cycle();
        check("lat_valid", job_valid, 1);
        wait_all_done(300);
        check("t1_accepts", n_acc, 42);
        check("t1_ts_done", n_ts_done, 2);
        check("t1_all_done", n_all_done, 1);
        check("t1_sb_empty", exp_q.size(), 0);
        cycle();
        check("t1_idle", busy, 0);

        // 2: no completions -> five offers then stall; a completion frees PE2
        do_reset();
        for (int k = 0; k < NUM_PE; k++) exp_q.push_back(mk(k, 1, k));
        exp_q.push_back(mk(2, 1, 5));
        job_ready = 1'b1; start = 1'b1;
        cycle();
        start = 1'b0;
        repeat (8) cycle();
        check("t2_accepts", n_acc, 5);
        check("t2_stall", job_valid, 0);
        cmpl_valid = 1'b1; cmpl_pe = pe_id_t'(2);
        cycle();
        check("t2_cmpl_edge", job_valid, 0);
        cycle();
        check("t2_valid", job_valid, 1);
        check("t2_pe", job_pe, 2);
        check("t2_row", job_row, 5);
        cycle();
        check("t2_accepts_after", n_acc, 6);
        check("t2_sb_empty", exp_q.size(), 0);

        // 3: held offer stays stable under backpressure and other completions
        do_reset();
        for (int k = 0; k < 4; k++) exp_q.push_back(mk(k, 1, k));
        job_ready = 1'b1; start = 1'b1;
        cycle();
        start = 1'b0;
        repeat (4) cycle();
        job_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (i == 1 || i == 4 || i == 7) begin
                cmpl_valid = 1'b1;
                cmpl_pe    = pe_id_t'(i / 3);
            end
            cycle();
            check("t3_hold_valid", job_valid, 1);
            check("t3_hold_pe", job_pe, 3);
            check("t3_hold_ts", job_ts, 1);
            check("t3_hold_row", job_row, 3);
        end
        check("t3_err", err_cmpl, 0);
        job_ready = 1'b1;
        cycle();
        job_ready = 1'b0;
        check("t3_accepts", n_acc, 4);
        check("t3_next_pe", job_pe, 4);
        check("t3_next_row", job_row, 4);

        // 4: barrier - PE3's last ts1 job completes 50 cycles late
        do_reset();
        for (int k = 0; k < NUM_ROWS; k++) exp_q.push_back(mk(k % NUM_PE, 1, k));
        exp_q.push_back(mk(1, 2, 0));
        job_ready = 1'b1; auto_cmpl = 1'b1;
        lat_override_k = 18; lat_override = 50;
        start = 1'b1;
        cycle();
        start = 1'b0;
        seen = 0;
        tsd_cyc = -1;
        for (int i = 0; i < 200 && n_acc < 22; i++) begin
            if (job_valid) check("t4_ts_gate", job_ts, (seen != 0) ? 2 : 1);
            cycle();
            if (ts_done && seen == 0) begin
                seen = 1;
                tsd_cyc = cyc;
            end
        end
        job_ready = 1'b0;
        check("t4_accepts", n_acc, 22);
        check("t4_ts_done_cycle", tsd_cyc, override_due + 1);
        check("t4_ts_done_count", n_ts_done, 1);

        // 5: illegal completions set a sticky flag cleared by the next start
        do_reset();
        push_layer();
        auto_cmpl = 1'b1; start = 1'b1;
        cycle();
        start = 1'b0;
        cycle();
        job_ready = 1'b1;
        cycle();
        job_ready = 1'b0;
        check("t5_err_clear", err_cmpl, 0);
        cmpl_valid = 1'b1; cmpl_pe = pe_id_t'(6);
        cycle();
        check("t5_err_range", err_cmpl, 1);
        check("t5_hold_pe", job_pe, 1);
        cmpl_valid = 1'b1; cmpl_pe = pe_id_t'(1);
        cycle();
        check("t5_err_idle_pe", err_cmpl, 1);
        check("t5_hold_row", job_row, 1);
        job_ready = 1'b1;
        wait_all_done(400);
        job_ready = 1'b0;
        check("t5_accepts", n_acc, 42);
        check("t5_sb_empty", exp_q.size(), 0);
        cycle();
        check("t5_err_sticky", err_cmpl, 1);
        start = 1'b1;
        cycle();
        start = 1'b0;
        check("t5_err_start", err_cmpl, 0);
        check("t5_busy_start", busy, 1);

        // 6: asynchronous reset between edges in ts2, then a clean restart
        do_reset();
        push_layer();
        job_ready = 1'b1; auto_cmpl = 1'b1; start = 1'b1;
        cycle();
        start = 1'b0;
        for (int i = 0; i < 200 && n_acc < 24; i++) cycle();
        check("t6_in_ts2", job_ts, 2);
        #3;
        rst_n = 1'b0;
        #1;
        check("t6_rst_valid", job_valid, 0);
        check("t6_rst_pe", job_pe, 0);
        check("t6_rst_ts", job_ts, 1);
        check("t6_rst_row", job_row, 0);
        check("t6_rst_busy", busy, 0);
        check("t6_rst_pulses", {30'd0, ts_done, all_done}, 0);
        clear_model();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        exp_q.push_back(mk(0, 1, 0));
        job_ready = 1'b1; start = 1'b1;
        cycle();
        start = 1'b0;
        cycle();
        check("t6_valid", job_valid, 1);
        check("t6_pe", job_pe, 0);
        check("t6_ts", job_ts, 1);
        check("t6_row", job_row, 0);
        cycle();
        job_ready = 1'b0;
        check("t6_sb_empty", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
